// File: rtl/pattern_resp_misr_if.sv
// Handshake and data bundle between the response compactor and the test controller.
// The controller side drives run requests, response samples and result acceptance.
interface pattern_resp_misr_if;
  logic        start;
  logic        resp_valid;
  logic [8:0]  resp_in;
  logic        busy;
  logic        sig_valid;
  logic        sig_ready;
  logic [15:0] signature;
  logic [15:0] change_cnt;

  modport master (
    output start, resp_valid, resp_in, sig_ready,
    input  busy, sig_valid, signature, change_cnt
  );

  modport slave (
    input  start, resp_valid, resp_in, sig_ready,
    output busy, sig_valid, signature, change_cnt
  );
endinterface

// File: rtl/pattern_resp_misr.sv
// Folds a programmable window of 9-bit netlist responses into a 16-bit MISR signature
// and counts sample-to-sample transitions; the result is offered over a valid/ready handshake.
module pattern_resp_misr #(
  parameter logic [15:0] WINDOW = 16'd16,
  parameter logic [15:0] POLY   = 16'h100B,
  parameter logic [15:0] SEED   = 16'h0000
) (
  input logic                blif_clk_net,
  input logic                blif_reset_net,
  pattern_resp_misr_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // One MISR shift: feedback taps apply when the outgoing MSB is set.
  function automatic logic [15:0] misr_step(input logic [15:0] sig, input logic [8:0] resp);
    logic [15:0] fb;
    fb = sig[15] ? POLY : 16'h0000;
    return {sig[14:0], 1'b0} ^ fb ^ {7'b000_0000, resp};
  endfunction

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_busy;
  logic        r_sig_valid;
  logic        w_busy_nxt;
  logic        w_sig_valid_nxt;
  logic [15:0] r_sig;
  logic [15:0] r_cnt;
  logic [15:0] r_num;
  logic [8:0]  r_prev;
  logic        w_accept;
  logic        w_last;
  logic        w_launch;

  assign w_launch = (r_state == ST_IDLE) && bus.start;
  assign w_accept = (r_state == ST_RUN) && bus.resp_valid;
  assign w_last   = w_accept && (r_num == (WINDOW - 16'd1));

  // State register.
  always_ff @(posedge blif_clk_net) begin
    if (blif_reset_net) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: start only counts in IDLE, HOLD leaves only on a completed handshake.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) w_state_nxt = ST_RUN;
        else           w_state_nxt = ST_IDLE;
      end
      ST_RUN: begin
        if (w_last) w_state_nxt = ST_HOLD;
        else        w_state_nxt = ST_RUN;
      end
      ST_HOLD: begin
        if (r_sig_valid && bus.sig_ready) w_state_nxt = ST_IDLE;
        else                              w_state_nxt = ST_HOLD;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so the flags can be registered.
  always_comb begin
    w_busy_nxt      = 1'b0;
    w_sig_valid_nxt = 1'b0;
    case (w_state_nxt)
      ST_IDLE: begin
        w_busy_nxt      = 1'b0;
        w_sig_valid_nxt = 1'b0;
      end
      ST_RUN: begin
        w_busy_nxt      = 1'b1;
        w_sig_valid_nxt = 1'b0;
      end
      ST_HOLD: begin
        w_busy_nxt      = 1'b1;
        w_sig_valid_nxt = 1'b1;
      end
      default: begin
        w_busy_nxt      = 1'b0;
        w_sig_valid_nxt = 1'b0;
      end
    endcase
  end

  // Registered status flags.
  always_ff @(posedge blif_clk_net) begin
    if (blif_reset_net) begin
      r_busy      <= 1'b0;
      r_sig_valid <= 1'b0;
    end else begin
      r_busy      <= w_busy_nxt;
      r_sig_valid <= w_sig_valid_nxt;
    end
  end

  // Datapath: signature, transition counter, previous sample and sample index.
  always_ff @(posedge blif_clk_net) begin
    if (blif_reset_net) begin
      r_sig  <= 16'h0000;
      r_cnt  <= 16'h0000;
      r_num  <= 16'h0000;
      r_prev <= 9'h000;
    end else if (w_launch) begin
      r_sig  <= SEED;
      r_cnt  <= 16'h0000;
      r_num  <= 16'h0000;
      r_prev <= 9'h000;
    end else if (w_accept) begin
      r_sig  <= misr_step(r_sig, bus.resp_in);
      if ((bus.resp_in != r_prev) && (r_cnt != 16'hFFFF)) begin
        r_cnt <= r_cnt + 16'd1;
      end
      r_prev <= bus.resp_in;
      r_num  <= r_num + 16'd1;
    end
  end

  assign bus.busy       = r_busy;
  assign bus.sig_valid  = r_sig_valid;
  assign bus.signature  = r_sig;
  assign bus.change_cnt = r_cnt;

endmodule
